rv_fetch: RTL
=============

Name: rv_fetch

Overview:
- Instruction fetch sequencer for the RV32 core; sits between instruction memory and rv_decode.
- Owns the PC and issues in-order fetch requests with credit-based flow control.
- Pairs each returned word with its PC and buffers it for decode.
- Applies redirects from execute, flushing buffered words and discarding stale in-flight responses.

Parameters:
XLEN, 32, address/PC width.
RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0).
DEPTH, 2, max words in flight plus buffered; power of two, >=2.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous, active-low reset.
imem_req_valid_o  out  1  fetch request valid.
imem_req_ready_i  in  1  memory accepts request this cycle.
imem_req_addr_o  out  XLEN  word-aligned fetch address.
imem_rsp_valid_i  in  1  response word valid. Responses are in order, arrive >=1 cycle after acceptance and cannot be stalled.
imem_rsp_data_i  in  32  instruction word.
redirect_valid_i  in  1  one-cycle redirect pulse.
redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored and forced to 0.
insn_valid_o  out  1  instruction available to decode.
insn_ready_i  in  1  decode consumes instruction.
insn_o  out  32  instruction word (to rv_decode insn_i).
insn_pc_o  out  XLEN  PC of insn_o.

Behaviour:
- Reset (async assert, sync release):
  - pc_q=RESET_PC; inflight=0, count=0, drop=0.
  - imem_req_valid_o=0, insn_valid_o=0; insn_o=0 and insn_pc_o=0 while empty.
- Credit rule: imem_req_valid_o = (inflight + count < DEPTH) && !redirect_valid_i.
  - imem_req_addr_o = pc_q.
- Request accepted when valid && ready:
  - Push pc_q into the in-flight PC queue (DEPTH entries); pc_q += 4, wrapping modulo 2^XLEN; inflight++.
- Response arrives (imem_rsp_valid_i):
  - If drop>0: drop--, inflight--, word discarded.
  - Else: pop the PC queue, push {word, pc} into the output FIFO (count++), inflight--.
- Output FIFO:
  - Show-ahead; insn_valid_o = (count>0).
  - Pop on insn_valid_o && insn_ready_i.
  - Response push and decode pop in the same cycle leave count unchanged.
  - Zero-latency bypass is not required; earliest insn_valid_o is the cycle after the response.
- Redirect (redirect_valid_i=1):
  - pc_q <= redirect_pc_i & ~3.
  - Output FIFO and PC queue cleared; count=0; insn_valid_o=0 the next cycle.
  - drop <= inflight_next, i.e. all responses still outstanding after this cycle's response handling, including one that arrives this cycle if it would otherwise be kept.
  - No request is issued in the redirect cycle. First request to the new PC is the following cycle.
  - A response arriving in the redirect cycle is discarded. A decode pop in the redirect cycle is honoured (the word was presented) but flushed state wins.
- Back-to-back redirects: the last one wins; drop accumulates correctly.
- Ordering invariants:
  - inflight + count <= DEPTH always.
  - A response with inflight==0 is a protocol error: ignore it; a simulation-only assertion fires.
- FSM, derived from counters:
  - RUN: normal issue.
  - FULL: credits exhausted.
  - FLUSH: drop>0; issue continues to the new PC, but new responses are kept only after drop reaches 0.
  - Transitions: RUN->FULL when inflight+count==DEPTH; FULL->RUN on a pop or discard freeing a credit; any->FLUSH on a redirect with outstanding requests; FLUSH->RUN/FULL when drop reaches 0.
  - Expose as an internal enum for debug only.
- Throughput: with a 1-cycle memory and insn_ready_i=1, DEPTH=2 sustains 1 instruction/cycle.

Decomposition:
- Shared package rv_pkg:
  - XLEN default and ILEN=32.
  - INSN_NOP=32'h0000_0013.
  - fetch_state_e enum {RUN, FULL, FLUSH}.
  - fetch_entry_t struct {logic [31:0] insn; logic [XLEN-1:0] pc;}.
- One sub-module, rv_fifo: parameterised show-ahead FIFO (WIDTH, DEPTH) with push, pop, flush, count. Instantiated twice: PC queue and output FIFO.

Test Plan:
- Reset, RESET_PC=32'h100, memory ready, 1-cycle latency, decode ready -> requests 0x100, 0x104, 0x108 on consecutive cycles; insn_pc_o follows one cycle after each response; no bubbles after the first.
- Decode stalls (insn_ready_i=0) for 10 cycles -> exactly DEPTH=2 requests issued, imem_req_valid_o then low; on release, words 0x100 and 0x104 delivered in order, and the next request goes out as the first pop frees a credit.
- imem_req_ready_i=0 for 5 cycles with valid high -> addr held at 0x100, pc_q unchanged; accepted on ready.
- Redirect to 0x2002 with 2 requests in flight at 3-cycle latency -> both stale responses discarded; first request addr is 0x2000 the cycle after the redirect; first delivered insn_pc_o=0x2000.
- Redirect coincident with a response and a decode pop -> response dropped, FIFO empty next cycle, no duplicate or stale PC ever appears.
- PC at 32'hFFFF_FFFC -> next request addr 32'h0000_0000. Async reset asserted mid-burst -> all outputs low immediately; restart fetches RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg: definitions shared by the RV32 front-end blocks.
//   XLEN          default address/PC width
//   ILEN          instruction word width
//   INSN_NOP      canonical NOP (addi x0, x0, 0)
//   fetch_state_e debug view of the fetch sequencer (RUN / FULL / FLUSH)
//   fetch_entry_t one decoded-bound slot: instruction word plus its PC
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FULL  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fifo.sv
// -----------------------------------------------------------------------------
// rv_fifo: show-ahead FIFO with synchronous flush.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i/data_i  write one entry (ignored when full without a pop)
//   pop_i          remove the head entry (ignored when empty)
//   flush_i        drop every entry; wins over push and pop
//   data_o         current head entry (stale content when empty)
//   count_o        number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module rv_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push_ok = push_i && ((count_q != DEPTH_W) || pop_ok);

  // NOTE: storage has no reset; the pointers and count define which entries
  // are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rv_fetch.sv
// -----------------------------------------------------------------------------
// rv_fetch: instruction fetch sequencer between instruction memory and decode.
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   imem_req_valid_o/ready_i      fetch request handshake
//   imem_req_addr_o               word-aligned fetch address (the PC)
//   imem_rsp_valid_i/data_i       in-order response word, cannot be stalled
//   redirect_valid_i/redirect_pc_i one-cycle redirect from execute
//   insn_valid_o/insn_ready_i     show-ahead handshake towards decode
//   insn_o, insn_pc_o             instruction word and its PC (0 when empty)
//
// Every issued request holds one credit until its word either leaves through
// decode or is discarded as stale. A redirect flushes buffered words and the
// PC queue and marks all still-outstanding responses for dropping.
// -----------------------------------------------------------------------------
module rv_fetch
  import rv_pkg::*;
#(
  parameter int unsigned           XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]       RESET_PC = {XLEN{1'b0}},
  parameter int unsigned           DEPTH    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     imem_req_valid_o,
  input  logic                     imem_req_ready_i,
  output logic [XLEN-1:0]          imem_req_addr_o,
  input  logic                     imem_rsp_valid_i,
  input  logic [ILEN-1:0]          imem_rsp_data_i,
  input  logic                     redirect_valid_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic                     insn_valid_o,
  input  logic                     insn_ready_i,
  output logic [ILEN-1:0]          insn_o,
  output logic [XLEN-1:0]          insn_pc_o
);

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  // Same layout as fetch_entry_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   drop_q;
  logic            active_q;

  logic [CW-1:0]   inflight_d;
  logic [CW-1:0]   out_count;
  logic [CW-1:0]   pcq_count;
  logic [XLEN-1:0] pcq_head;
  entry_t          out_head;
  entry_t          out_push_data;
  logic [CW:0]     credit_used;

  logic            req_fire;
  logic            rsp_v;
  logic            rsp_keep;
  logic            rsp_discard;
  logic            insn_pop;

  fetch_state_e    state;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_v       = imem_rsp_valid_i && (inflight_q != '0);
  assign rsp_discard = rsp_v && (drop_q != '0);
  // In a redirect cycle a response that would otherwise be kept is stale too.
  assign rsp_keep    = rsp_v && (drop_q == '0) && !redirect_valid_i;

  assign insn_valid_o = (out_count != '0);
  assign insn_pop     = insn_valid_o && insn_ready_i;

  // Credits in use, with this cycle's decode pop and stale discard already
  // returned: that is what lets DEPTH=2 keep up with a 1-cycle memory and lets
  // the first post-redirect request go out while stale words drain.
  assign credit_used = {1'b0, inflight_q} + {1'b0, out_count}
                     - (CW+1)'(insn_pop) - (CW+1)'(rsp_discard);

  // active_q holds requests off until the first cycle after reset release.
  assign imem_req_valid_o = active_q && (credit_used < DEPTH_W) && !redirect_valid_i;
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_v);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every right-hand side above reads
      // the pre-edge value regardless of statement order.
      active_q   <= 1'b1;
      inflight_q <= inflight_d;
      if (redirect_valid_i) begin
        pc_q   <= redirect_pc_i & ALIGN_MASK;
        // Everything still outstanding after this cycle belongs to the old
        // stream; a second redirect simply re-counts, so the last one wins.
        drop_q <= inflight_d;
      end else begin
        if (req_fire)    pc_q   <= pc_q + XLEN'(4);
        if (rsp_discard) drop_q <= drop_q - CW'(1);
      end
    end
  end

  // PC of every request whose word will be kept, in issue order.
  rv_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (rsp_keep),
    .flush_i (redirect_valid_i),
    .data_o  (pcq_head),
    .count_o (pcq_count)
  );

  always_comb begin
    out_push_data      = '0;
    out_push_data.insn = imem_rsp_data_i;
    out_push_data.pc   = pcq_head;
  end

  // Words waiting for decode, paired with their PC.
  rv_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rsp_keep),
    .data_i  (out_push_data),
    .pop_i   (insn_pop),
    .flush_i (redirect_valid_i),
    .data_o  (out_head),
    .count_o (out_count)
  );

  assign insn_o    = insn_valid_o ? out_head.insn : '0;
  assign insn_pc_o = insn_valid_o ? out_head.pc   : '0;

  // Debug view of the sequencer, derived purely from the counters.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state unassigned and
    // no latch is inferred.
    state = RUN;
    if (drop_q != '0) begin
      state = FLUSH;
    end else if (({1'b0, inflight_q} + {1'b0, out_count}) == DEPTH_W) begin
      state = FULL;
    end
  end

  // Simulation-only consistency checks; synthesis ignores immediate asserts.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(imem_rsp_valid_i && (inflight_q == '0)));
      assert (({1'b0, inflight_q} + {1'b0, out_count}) <= DEPTH_W);
      assert (pcq_count == (inflight_q - drop_q));
      assert (state != FULL || !imem_req_valid_o || insn_pop);
    end
  end

endmodule
